// File: rtl/rv32i_types.sv
// Shared type definitions for the cache-to-burst-memory adapter.
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_DATA,
    RESP
  } adapter_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } mem_grant_t;

endpackage

// File: rtl/cache_mem_adapter.sv
// Arbitrates icache/dcache line requests onto a 4-beat burst memory,
// one transaction at a time, with round-robin grant on contention.
module cache_mem_adapter
  import rv32i_types::*;
#(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [31:0]          i_dfp_addr,
  input  logic                 i_dfp_read,
  output logic [LINE_BITS-1:0] i_dfp_rdata,
  output logic                 i_dfp_resp,

  input  logic [31:0]          d_dfp_addr,
  input  logic                 d_dfp_read,
  input  logic                 d_dfp_write,
  input  logic [LINE_BITS-1:0] d_dfp_wdata,
  output logic [LINE_BITS-1:0] d_dfp_rdata,
  output logic                 d_dfp_resp,

  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = $clog2(BEATS);

  adapter_state_t       state, state_next;
  mem_grant_t           grant, last_grant, grant_sel;
  logic [CNT_W-1:0]     beat_cnt;
  logic [31:0]          addr_q;
  logic [LINE_BITS-1:0] line_q;
  logic                 i_req, d_req, any_req;
  logic                 beat_hit, last_beat;

  assign i_req     = i_dfp_read;
  assign d_req     = d_dfp_read | d_dfp_write;
  assign any_req   = i_req | d_req;
  assign beat_hit  = bmem_rvalid && (bmem_raddr == addr_q);
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  // Round-robin only matters on contention; a lone requester always wins.
  always_comb begin
    grant_sel = ICACHE;
    if (i_req && d_req)
      grant_sel = (last_grant == ICACHE) ? DCACHE : ICACHE;
    else if (d_req)
      grant_sel = DCACHE;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)
                 state_next = (grant_sel == DCACHE && d_dfp_write) ? WR_DATA : RD_CMD;
      RD_CMD:  if (bmem_ready) state_next = RD_DATA;
      RD_DATA: if (beat_hit && last_beat) state_next = RESP;
      WR_DATA: if (bmem_ready && last_beat) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control registers: state, beat counter and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      grant      <= ICACHE;
      last_grant <= DCACHE;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (any_req) grant <= grant_sel;
        end
        RD_CMD:  if (bmem_ready) beat_cnt <= '0;
        RD_DATA: if (beat_hit) beat_cnt <= beat_cnt + CNT_W'(1);
        WR_DATA: if (bmem_ready) beat_cnt <= beat_cnt + CNT_W'(1);
        RESP:    last_grant <= grant;
        default: ;
      endcase
    end
  end

  // Datapath registers: latched address and the line being filled or drained.
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      addr_q <= (grant_sel == DCACHE) ? d_dfp_addr : i_dfp_addr;
      if (grant_sel == DCACHE && d_dfp_write)
        line_q <= d_dfp_wdata;
    end else if (state == RD_DATA && beat_hit) begin
      line_q[int'(beat_cnt)*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
    end
  end

  // Outputs are decoded from state so that reset silences every port.
  always_comb begin
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_addr   = '0;
    bmem_wdata  = '0;
    i_dfp_resp  = 1'b0;
    d_dfp_resp  = 1'b0;
    i_dfp_rdata = '0;
    d_dfp_rdata = '0;
    case (state)
      RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      WR_DATA: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[int'(beat_cnt)*BEAT_BITS +: BEAT_BITS];
      end
      RESP: begin
        if (grant == ICACHE) begin
          i_dfp_resp  = 1'b1;
          i_dfp_rdata = line_q;
        end else begin
          d_dfp_resp  = 1'b1;
          d_dfp_rdata = line_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_adapter.sv
// Randomized bench: cache request agents, a burst-memory model with stale
// beats, and a line-level reference for arbitration and data integrity.
module tb_cache_mem_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_dfp_addr;
  logic         i_dfp_read;
  logic [255:0] i_dfp_rdata;
  logic         i_dfp_resp;
  logic [31:0]  d_dfp_addr;
  logic         d_dfp_read;
  logic         d_dfp_write;
  logic [255:0] d_dfp_wdata;
  logic [255:0] d_dfp_rdata;
  logic         d_dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  always #5 clk = ~clk;

  cache_mem_adapter dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
    .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Memory contents as seen by the burst memory, one entry per line address.
  logic [255:0] mem [logic [31:0]];

  // Cache agents: pending flag, op and operands held until their response.
  logic         ip, dp, dw;
  logic [31:0]  ia, da;
  logic [255:0] dwd;

  // Current transaction as the reference sees it.
  logic         busy, cur_w, rd_acc;
  int           cur_g, last_served, wr_idx, rd_sent, wait_cnt;
  logic [31:0]  cur_a;
  logic [255:0] cur_line;
  logic         bi, bd, abort, did_reset;
  int           g;

  localparam int NCYC = 6000;

  task automatic drive_reqs();
    i_dfp_read  = ip;
    i_dfp_addr  = ia;
    d_dfp_read  = dp && !dw;
    d_dfp_write = dp && dw;
    d_dfp_addr  = da;
    d_dfp_wdata = dwd;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_i_resp"}, i_dfp_resp, 0);
    check({tag, "_d_resp"}, d_dfp_resp, 0);
    check({tag, "_bmem_read"}, bmem_read, 0);
    check({tag, "_bmem_write"}, bmem_write, 0);
    check({tag, "_bmem_addr"}, bmem_addr, 0);
    check({tag, "_bmem_wdata"}, bmem_wdata, 0);
    check({tag, "_i_rdata"}, i_dfp_rdata, 0);
    check({tag, "_d_rdata"}, d_dfp_rdata, 0);
  endtask

  initial begin
    rst = 1'b1;
    ip = 0; dp = 0; dw = 0; ia = '0; da = '0; dwd = '0;
    drive_reqs();
    bmem_ready = 0; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
    busy = 0; cur_w = 0; rd_acc = 0; cur_g = 0; last_served = 1;
    wr_idx = 0; rd_sent = 0; wait_cnt = 0; cur_a = '0; cur_line = '0;
    abort = 0; did_reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");

    // Both caches request in the very first sampled cycle.
    rst = 1'b0;
    ip = 1; ia = 32'h0000_1000;
    dp = 1; dw = 1; da = 32'h0000_2040; dwd = rand_line();
    drive_reqs();
    bmem_ready = 1;

    for (int cyc = 0; cyc < NCYC && !abort; cyc++) begin
      @(posedge clk);
      #1;
      if (rst) begin
        check_quiet("midrst");
        rst = 1'b0;
        busy = 0; last_served = 1; ip = 0; dp = 0;
        rd_sent = 0; wr_idx = 0; rd_acc = 0; wait_cnt = 0;
        did_reset = 1;
      end else begin
        if (i_dfp_resp || d_dfp_resp) begin
          check("resp_when_busy", busy, 1);
          check("resp_i_sel", i_dfp_resp, busy && cur_g == 0);
          check("resp_d_sel", d_dfp_resp, busy && cur_g == 1);
          if (busy) begin
            if (cur_w) begin
              check("wr_beats", wr_idx, 4);
              mem[cur_a] = cur_line;
            end else begin
              check("rd_beats", rd_sent, 4);
              check("rdata", (cur_g == 0) ? i_dfp_rdata : d_dfp_rdata, mem[cur_a]);
            end
            if (cur_g == 0) ip = 0; else dp = 0;
            last_served = cur_g;
            busy = 0;
            wait_cnt = 0;
          end
        end else if (!busy && (bmem_read || bmem_write)) begin
          bi = i_dfp_read;
          bd = d_dfp_read || d_dfp_write;
          check("start_has_req", bi || bd, 1);
          if (bi && bd) g = 1 - last_served;
          else          g = bd ? 1 : 0;
          cur_g    = g;
          cur_a    = (g == 1) ? d_dfp_addr : i_dfp_addr;
          cur_w    = (g == 1) && d_dfp_write;
          cur_line = d_dfp_wdata;
          check("start_addr", bmem_addr, cur_a);
          check("start_op", bmem_write, cur_w);
          if (!cur_w && !mem.exists(cur_a)) mem[cur_a] = rand_line();
          busy = 1; wr_idx = 0; rd_sent = 0; rd_acc = 0; wait_cnt = 0;
        end

        if (busy) begin
          if (cur_w) begin
            check("wr_no_read", bmem_read, 0);
            if (wr_idx < 4) begin
              check("wr_valid", bmem_write, 1);
              check("wr_addr", bmem_addr, cur_a);
              check("wr_data", bmem_wdata, cur_line[64*wr_idx +: 64]);
            end else begin
              check("wr_extra_beat", bmem_write, 0);
            end
          end else begin
            check("rd_no_write", bmem_write, 0);
            check("rd_cmd", bmem_read, !rd_acc);
            if (!rd_acc) check("rd_addr", bmem_addr, cur_a);
          end
        end else begin
          check("idle_bmem_read", bmem_read, 0);
          check("idle_bmem_write", bmem_write, 0);
        end

        if (busy || ip || dp) wait_cnt++;
        if (wait_cnt > 300) begin
          check("progress_timeout", 0, 1);
          abort = 1;
        end
      end

      // Abandon a read after exactly two accepted beats.
      if (!did_reset && cyc > 2000 && busy && !cur_w && rd_acc && rd_sent == 2) begin
        rst = 1'b1;
        ip = 0; dp = 0;
        drive_reqs();
        bmem_ready = 0; bmem_rvalid = 0;
      end else begin
        if (!ip && $urandom_range(3) == 0) begin
          ip = 1;
          ia = 32'h0000_1000 + {24'd0, 3'($urandom_range(7)), 5'd0};
        end
        if (!dp && $urandom_range(3) == 0) begin
          dp  = 1;
          dw  = 1'($urandom_range(1));
          da  = 32'h0000_8000 + {24'd0, 3'($urandom_range(7)), 5'd0};
          dwd = rand_line();
        end
        drive_reqs();

        bmem_ready  = ($urandom_range(3) != 0);
        bmem_rvalid = 0;
        bmem_raddr  = $urandom;
        bmem_rdata  = {$urandom, $urandom};
        if (busy && !cur_w && rd_acc && rd_sent < 4 && $urandom_range(1) == 1) begin
          bmem_rvalid = 1;
          bmem_raddr  = cur_a;
          bmem_rdata  = mem[cur_a][64*rd_sent +: 64];
          rd_sent++;
        end else if ($urandom_range(2) == 0) begin
          bmem_rvalid = 1;
          bmem_raddr  = busy ? (cur_a ^ 32'h0000_0040) : (cur_a ^ 32'h0010_0000);
        end

        if (busy) begin
          if (!cur_w && bmem_read && bmem_ready) rd_acc = 1;
          if (cur_w && bmem_write && bmem_ready && wr_idx < 4) wr_idx++;
        end
      end

      assert (!(d_dfp_read && d_dfp_write));
    end

    if (!abort) check("mid_burst_reset_hit", did_reset, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
